pr_data_mem: RTL and testbench
==============================

Name: pr_data_mem

Overview:
Parametrised successor to the single-cycle word data memory. It adds a valid/ready request/response handshake, configurable read latency and depth, and byte/half/word accesses with sign or zero extension. It also flags misaligned, out-of-range and illegal-size accesses, and zero-initialises itself after every reset. The block sits behind the datapath load/store unit as its data memory.

Parameters:
DEPTH, 256, number of 32-bit words; power of two, 16..65536.
ADDR_W, 32, width of the byte address.
RD_LAT, 1, cycles from request acceptance to RSP_VALID; legal range 1..4.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RST  in  1  asynchronous, active-high reset.
REQ_VALID  in  1  request present.
REQ_READY  out  1  block can accept a request.
ADDR  in  ADDR_W  byte address.
RW  in  1  0 = read, 1 = write.
SIZE  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
SIGNED  in  1  reads only: 1 = sign-extend, 0 = zero-extend.
WD  in  32  write data, right-aligned (byte in [7:0], half in [15:0]).
RSP_VALID  out  1  response present.
RSP_READY  in  1  consumer accepts the response.
RD  out  32  read data, extended to 32 bits; 0 for writes and errors.
ERR  out  1  access rejected; qualified by RSP_VALID.

Behaviour:
- Reset (asynchronous) forces:
  - state INIT, init counter 0;
  - REQ_READY=0, RSP_VALID=0, RD=0, ERR=0;
  - any pending request or response is discarded.
- FSM states: INIT, IDLE, WAIT, RESP.
- INIT:
  - writes zero to word[cnt] each cycle; cnt runs 0..DEPTH-1;
  - after the write of DEPTH-1, goes to IDLE;
  - total duration is exactly DEPTH cycles after RST deasserts.
- IDLE:
  - REQ_READY=1 only in this state;
  - a request is accepted on an edge where REQ_VALID and REQ_READY are both high;
  - ADDR, RW, SIZE, SIGNED and WD are captured at that edge;
  - next state is RESP if RD_LAT=1, otherwise WAIT.
- WAIT:
  - a counter holds the state for RD_LAT-1 cycles, then moves to RESP;
  - RSP_VALID therefore rises exactly RD_LAT cycles after the accepting edge.
- RESP:
  - RSP_VALID=1; RD and ERR are held stable while RSP_READY=0;
  - an edge with RSP_READY=1 clears RSP_VALID and returns to IDLE;
  - the earliest next accept is the following edge, so minimum request spacing is RD_LAT+1 cycles;
  - this spacing means there is no read-after-write hazard.
- Every request, including writes, produces exactly one response.
- Addressing:
  - word index = ADDR[log2(DEPTH)+1:2]; lane = ADDR[1:0];
  - little-endian: lane 0 = bits [7:0].
- ERR=1 when any of the following holds:
  - SIZE=11;
  - half access with ADDR[0]=1;
  - word access with ADDR[1:0]≠00;
  - ADDR ≥ 4*DEPTH.
- On ERR: memory is unchanged and RD=0.
- Writes are committed at the accepting edge, to the addressed lanes only:
  - byte writes WD[7:0] into lane ADDR[1:0];
  - half writes WD[15:0] into lanes ADDR[1]*2 and ADDR[1]*2+1;
  - word writes all four lanes;
  - untouched lanes keep their contents.
- Reads: the addressed byte or half is right-aligned in RD, then sign- or zero-extended per SIGNED; word reads ignore SIGNED.
- RST asserted in WAIT or RESP: RSP_VALID drops immediately and no response is delivered. A write already accepted is lost anyway, because INIT re-zeroes the array.
- Inputs are don't-care outside IDLE.

Test Plan:
- Reset release, DEPTH=256, RD_LAT=2 → REQ_READY=0 for 256 cycles, then 1. Word reads at ADDR 0,4,…,36 → RD=0, ERR=0, RSP_VALID exactly 2 cycles after each accept.
- Word writes WD=i to ADDR=4i for i=0..9, then read back → RD=i, ERR=0. Each write response has RD=0.
- Byte write 0x80 to ADDR 0x41:
  - signed byte read at 0x41 → 0xFFFFFF80;
  - unsigned byte read at 0x41 → 0x00000080;
  - word read at 0x40 → 0x00008000.
  - Then half write 0xBEEF to 0x42 → word read at 0x40 → 0xBEEF8000.
- Half read at 0x43 → ERR=1, RD=0. SIZE=11 read at 0x0 → ERR=1. Word write 0x12345678 to 0x400 → ERR=1, and a word read at 0x0 still returns 0.
- Backpressure: hold RSP_READY=0 for 5 cycles after RSP_VALID rises → RSP_VALID, RD and ERR stable, REQ_READY=0. Release → RSP_VALID=0 next edge, REQ_READY=1.
- Write 0x55 to ADDR 0x8, issue a read of 0x8, assert RST during WAIT → RSP_VALID=0 immediately, no response. After INIT (256 cycles), read 0x8 → 0.

Source files
------------

// File: rtl/pr_data_mem.sv
// pr_data_mem: word-organised data memory behind the load/store unit.
//
// Accepts one request at a time over a valid/ready handshake and returns
// exactly one response per request, RD_LAT cycles after acceptance.
// Supports byte / half / word accesses (little-endian lanes), sign or zero
// extension on narrow reads, and flags illegal size, misalignment and
// out-of-range addresses. The array is zeroed one word per cycle after
// every reset before the first request is accepted.
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_rst        asynchronous active-high reset
//   i_req_valid  request present
//   o_req_ready  request can be accepted (idle only)
//   i_addr       byte address
//   i_rw         0 = read, 1 = write
//   i_size       00 byte, 01 half, 10 word, 11 illegal
//   i_signed     narrow reads: 1 = sign-extend, 0 = zero-extend
//   i_wd         write data, right-aligned
//   o_rsp_valid  response present
//   i_rsp_ready  consumer takes the response
//   o_rd         read data (0 for writes and errors)
//   o_err        access rejected, qualified by o_rsp_valid
module pr_data_mem #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_rw,
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  input  logic [31:0]       i_wd,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rd,
  output logic              o_err
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);
  // Last value of the wait counter before moving to RESP.
  localparam logic [1:0]    LAT_LAST = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_cnt;
  logic [1:0]    r_lat;
  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_rd;
  logic          r_err;

  logic          w_accept;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic          w_bad_size;
  logic          w_misalign;
  logic          w_oor;
  logic          w_err;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_rdata;
  logic [31:0]   w_wdata;
  logic [3:0]    w_wmask;

  // ---------------------------------------------------------------------
  // Address decode and access checks
  // ---------------------------------------------------------------------
  assign w_idx      = i_addr[AW+1:2];
  assign w_lane     = i_addr[1:0];
  assign w_bad_size = (i_size == 2'b11);
  assign w_misalign = ((i_size == 2'b01) && i_addr[0]) ||
                      ((i_size == 2'b10) && (i_addr[1:0] != 2'b00));
  // Any address bit above the array span means ADDR >= 4*DEPTH.
  assign w_oor      = |(i_addr >> (AW + 2));
  assign w_err      = w_bad_size || w_misalign || w_oor;

  assign w_word     = r_mem[w_idx];

  // ---------------------------------------------------------------------
  // Read extraction and extension
  // ---------------------------------------------------------------------
  always_comb begin
    w_byte  = w_word[7:0];
    w_half  = w_word[15:0];
    w_rdata = '0;
    case (w_lane)
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
    if (i_addr[1]) begin
      w_half = w_word[31:16];
    end
    if (!w_err && !i_rw) begin
      case (i_size)
        2'b00:   w_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
        2'b01:   w_rdata = {{16{i_signed & w_half[15]}}, w_half};
        default: w_rdata = w_word;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Write lane mask; data is replicated so every lane sees its bytes
  // ---------------------------------------------------------------------
  always_comb begin
    w_wmask = '0;
    w_wdata = i_wd;
    case (i_size)
      2'b00: begin
        w_wmask = 4'b0001 << w_lane;
        w_wdata = {4{i_wd[7:0]}};
      end
      2'b01: begin
        w_wmask = i_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_wd[15:0]}};
      end
      2'b10:   w_wmask = 4'b1111;
      default: w_wmask = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM next state and handshake outputs
  // ---------------------------------------------------------------------
  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_rd        = '0;
    o_err       = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (r_cnt == CNT_LAST) begin
          w_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          w_accept = 1'b1;
          w_next   = (RD_LAT <= 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_lat == LAT_LAST) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        o_rsp_valid = 1'b1;
        o_rd        = r_rd;
        o_err       = r_err;
        if (i_rsp_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_INIT;
    endcase
  end

  // ---------------------------------------------------------------------
  // State, counters and captured response
  // ---------------------------------------------------------------------
  // The response is computed at the accepting edge: no other request can
  // touch the array until this one has been consumed, so the data cannot
  // go stale, and the request fields need not be held.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_lat   <= '0;
      r_rd    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_INIT) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == ST_WAIT) begin
        r_lat <= r_lat + 1'b1;
      end
      if (w_accept) begin
        r_lat <= '0;
        r_rd  <= w_rdata;
        r_err <= w_err;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Storage array: zero fill in INIT, lane writes on accepted stores
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_cnt] <= '0;
    end else if (w_accept && i_rw && !w_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_wmask[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_pr_data_mem.sv
module tb_pr_data_mem;

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] addr = '0;
  logic        rw = 1'b0;
  logic [1:0]  size = 2'b10;
  logic        sgn = 1'b0;
  logic [31:0] wd = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rd;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pr_data_mem #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_addr     (addr),
    .i_rw       (rw),
    .i_size     (size),
    .i_signed   (sgn),
    .i_wd       (wd),
    .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready),
    .o_rd       (rd),
    .o_err      (err)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: byte-addressed array, one request in flight, response
  // consumable RD_LAT edges after acceptance.
  // ---------------------------------------------------------------------
  logic [7:0]  m_mem [4*DEPTH];
  int          m_init_left = DEPTH;
  bit          m_out = 1'b0;
  int          m_age = 0;
  logic [31:0] m_rd = '0;
  bit          m_err = 1'b0;

  task automatic model_access(input logic [31:0] a, input logic w, input logic [1:0] sz,
                              input logic sg, input logic [31:0] d);
    int          n;
    logic [31:0] v;
    bit          e;
    e = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) ||
        (a >= 32'(4 * DEPTH));
    n = 1 << sz;
    v = '0;
    if (!e) begin
      if (w) begin
        for (int b = 0; b < n; b++) m_mem[int'(a) + b] = d[8*b +: 8];
      end else begin
        for (int b = 0; b < n; b++) v[8*b +: 8] = m_mem[int'(a) + b];
        if (sg && n < 4 && v[8*n-1]) begin
          for (int b = n; b < 4; b++) v[8*b +: 8] = 8'hFF;
        end
      end
    end
    m_rd  = v;
    m_err = e;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_init_left = DEPTH;
      m_out       = 1'b0;
      m_age       = 0;
      for (int j = 0; j < 4 * DEPTH; j++) m_mem[j] = 8'h00;
    end else if (m_init_left > 0) begin
      m_init_left--;
    end else if (!m_out) begin
      if (req_valid) begin
        model_access(addr, rw, size, sgn, wd);
        m_out = 1'b1;
        m_age = 1;
      end
    end else if (m_age >= RD_LAT) begin
      if (rsp_ready) m_out = 1'b0;
    end else begin
      m_age++;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always begin
    @(posedge clk);
    #2;
    chk("mdl req_ready", 32'(req_ready), 32'(m_init_left == 0 && !m_out));
    chk("mdl rsp_valid", 32'(rsp_valid), 32'(m_out && m_age >= RD_LAT));
    if (m_out && m_age >= RD_LAT) begin
      chk("mdl rd", rd, m_rd);
      chk("mdl err", 32'(err), 32'(m_err));
    end
  end

  // ---------------------------------------------------------------------
  // Directed transactions with literal expectations
  // ---------------------------------------------------------------------
  task automatic wait_init(input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!req_ready && k < 1000);
    chk({nm, " init cycles"}, k, DEPTH);
  endtask

  task automatic xact(input logic [31:0] a, input logic w, input logic [1:0] sz,
                      input logic sg, input logic [31:0] d, input logic [31:0] erd,
                      input logic eerr, input int hold, input string nm);
    int k;
    @(negedge clk);
    rsp_ready = (hold == 0);
    addr = a; rw = w; size = sz; sgn = sg; wd = d;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 600) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      chk({nm, " accept timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      return;
    end
    @(negedge clk);
    // Scramble the request fields: they must have been captured.
    req_valid = 1'b0;
    addr = $urandom; wd = $urandom; rw = 1'($urandom); size = 2'($urandom); sgn = 1'($urandom);
    k = 1;
    while (!rsp_valid && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " latency"}, k, RD_LAT);
    if (!rsp_valid) begin
      rsp_ready = 1'b1;
      return;
    end
    chk({nm, " rd"}, rd, erd);
    chk({nm, " err"}, 32'(err), 32'(eerr));
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        chk({nm, " hold valid"}, 32'(rsp_valid), 32'd1);
        chk({nm, " hold rd"}, rd, erd);
        chk({nm, " hold err"}, 32'(err), 32'(eerr));
        chk({nm, " hold req_ready"}, 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk({nm, " release valid"}, 32'(rsp_valid), 32'd0);
      chk({nm, " release req_ready"}, 32'(req_ready), 32'd1);
    end
  endtask

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;
  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;

  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rd", rd, 32'd0);
    chk("reset err", 32'(err), 32'd0);
    rst = 1'b0;
    wait_init("first");

    for (int i = 0; i < 10; i++) xact(32'(4*i), RD, SZ_W, 1'b0, 32'd0, 32'd0, 1'b0, 0, "zero rd");
    for (int i = 0; i < 10; i++) xact(32'(4*i), WR, SZ_W, 1'b0, 32'(i), 32'd0, 1'b0, 0, "wr idx");
    for (int i = 0; i < 10; i++) xact(32'(4*i), RD, SZ_W, 1'b0, 32'd0, 32'(i), 1'b0, 0, "rd idx");

    xact(32'h41, WR, SZ_B, 1'b0, 32'hAAAA_AA80, 32'd0, 1'b0, 0, "wr byte");
    xact(32'h41, RD, SZ_B, 1'b1, 32'd0, 32'hFFFF_FF80, 1'b0, 0, "rd sbyte");
    xact(32'h41, RD, SZ_B, 1'b0, 32'd0, 32'h0000_0080, 1'b0, 0, "rd ubyte");
    xact(32'h40, RD, SZ_W, 1'b1, 32'd0, 32'h0000_8000, 1'b0, 0, "rd word40");
    xact(32'h42, WR, SZ_H, 1'b0, 32'h1234_BEEF, 32'd0, 1'b0, 0, "wr half");
    xact(32'h40, RD, SZ_W, 1'b0, 32'd0, 32'hBEEF_8000, 1'b0, 0, "rd word40b");
    xact(32'h42, RD, SZ_H, 1'b1, 32'd0, 32'hFFFF_BEEF, 1'b0, 0, "rd shalf");
    xact(32'h40, RD, SZ_H, 1'b0, 32'd0, 32'h0000_8000, 1'b0, 0, "rd uhalf");

    xact(32'h43, RD, SZ_H, 1'b0, 32'd0, 32'd0, 1'b1, 0, "misalign half");
    xact(32'h42, RD, SZ_W, 1'b0, 32'd0, 32'd0, 1'b1, 0, "misalign word");
    xact(32'h0,  RD, SZ_X, 1'b0, 32'd0, 32'd0, 1'b1, 0, "bad size");
    xact(32'h400, WR, SZ_W, 1'b0, 32'h1234_5678, 32'd0, 1'b1, 0, "oor write");
    xact(32'h0,  RD, SZ_W, 1'b0, 32'd0, 32'd0, 1'b0, 0, "rd after oor");
    xact(32'h3FF, RD, SZ_B, 1'b0, 32'd0, 32'd0, 1'b0, 0, "last byte");

    xact(32'h4,  RD, SZ_W, 1'b0, 32'd0, 32'd1, 1'b0, 5, "backpressure");

    // Reset while a response is being held.
    xact(32'h8, WR, SZ_W, 1'b0, 32'h55, 32'd0, 1'b0, 0, "wr 0x8");
    @(negedge clk);
    rsp_ready = 1'b0;
    addr = 32'h8; rw = RD; size = SZ_W; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    k = 1;
    while (!rsp_valid && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk("resp-rst rd before", rd, 32'h55);
    rst = 1'b1;
    #1;
    chk("resp-rst valid", 32'(rsp_valid), 32'd0);
    chk("resp-rst rd", rd, 32'd0);
    @(negedge clk);
    rsp_ready = 1'b1;
    rst = 1'b0;
    wait_init("after resp reset");
    xact(32'h8, RD, SZ_W, 1'b0, 32'd0, 32'd0, 1'b0, 0, "rd 0x8 cleared");

    // Reset while waiting for the read latency.
    xact(32'h8, WR, SZ_W, 1'b0, 32'h55, 32'd0, 1'b0, 0, "wr 0x8 again");
    @(negedge clk);
    addr = 32'h8; rw = RD; size = SZ_W; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("wait-rst valid pre", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    #1;
    chk("wait-rst valid", 32'(rsp_valid), 32'd0);
    chk("wait-rst req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_init("after wait reset");
    xact(32'h8, RD, SZ_W, 1'b0, 32'd0, 32'd0, 1'b0, 0, "rd 0x8 after init");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
